// File: rtl/usb3_pkg.sv
// Types and widths shared by the FT601 transmit and receive interfaces.
package usb3_pkg;

    localparam int USB3_DATA_W = 32;
    localparam int USB3_BE_W   = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_TURN  = 2'd1,
        TX_WRITE = 2'd2,
        TX_HOLD  = 2'd3
    } usb3_tx_state_t;

endpackage

// File: rtl/usb3_tx_fifo.sv
// Show-ahead single-clock FIFO: the head word is visible on o_data while not empty.
module usb3_tx_fifo #(
    parameter  int DEPTH  = 16,
    parameter  int DATA_W = 36,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic [LVL_W-1:0]  o_level,
    output logic              o_full,
    output logic              o_empty
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_level == LVL_W'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // NOTE: storage has no reset; the pointers and level alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    // Pointers are exactly PTR_W bits, so they wrap mod DEPTH on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/usb3_tx_if.sv
// FT601 245-synchronous write path: buffers words from FPGA logic and bursts them to the host.
module usb3_tx_if
    import usb3_pkg::*;
#(
    parameter  int FIFO_DEPTH = 16,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   ftdi_clk,
    input  logic                   reset,
    input  logic                   FT_TXE,
    output logic                   FT_WR,
    output logic [USB3_DATA_W-1:0] usb3_data_out,
    output logic [USB3_BE_W-1:0]   usb3_be_out,
    output logic                   usb3_data_oe,
    input  logic                   rx_active,
    output logic                   tx_busy,
    input  logic                   push_word,
    input  logic [USB3_DATA_W-1:0] push_data,
    input  logic [USB3_BE_W-1:0]   push_be,
    output logic                   fifo_full,
    output logic [LVL_W-1:0]       fifo_level,
    output logic                   overflow,
    output logic [31:0]            words_sent
);

    usb3_tx_state_t                      r_state;
    usb3_tx_state_t                      w_next;
    logic                                w_pop;
    logic                                w_accept;
    logic                                w_empty;
    logic [USB3_BE_W+USB3_DATA_W-1:0]    w_head;
    logic                                r_ft_wr_n;
    logic                                r_oe;
    logic [USB3_DATA_W-1:0]              r_data;
    logic [USB3_BE_W-1:0]                r_be;
    logic                                r_overflow;
    logic [31:0]                         r_words_sent;

    usb3_tx_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (USB3_BE_W + USB3_DATA_W)
    ) u_fifo (
        .clk     (ftdi_clk),
        .rst     (reset),
        .i_push  (push_word),
        .i_data  ({push_be, push_data}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_level (fifo_level),
        .o_full  (fifo_full),
        .o_empty (w_empty)
    );

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_next   = r_state;
        w_pop    = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            TX_IDLE: begin
                if (!w_empty && !FT_TXE && !rx_active) begin
                    w_pop  = 1'b1;
                    w_next = TX_TURN;
                end
            end
            TX_TURN:  w_next = FT_TXE ? TX_HOLD : TX_WRITE;
            TX_WRITE: begin
                if (FT_TXE) begin
                    w_next = TX_HOLD;
                end else begin
                    w_accept = 1'b1;
                    if (!w_empty && !rx_active) w_pop  = 1'b1;
                    else                        w_next = TX_IDLE;
                end
            end
            TX_HOLD:  if (!FT_TXE) w_next = TX_WRITE;
            default:  w_next = TX_IDLE;
        endcase
    end

    // NOTE: state and pad registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ftdi_clk or posedge reset) begin
        if (reset) begin
            r_state      <= TX_IDLE;
            r_ft_wr_n    <= 1'b1;
            r_oe         <= 1'b0;
            r_data       <= '0;
            r_be         <= '0;
            r_overflow   <= 1'b0;
            r_words_sent <= '0;
        end else begin
            r_state   <= w_next;
            r_ft_wr_n <= (w_next != TX_WRITE);
            r_oe      <= (w_next != TX_IDLE);
            if (w_pop) begin
                r_data <= w_head[USB3_DATA_W-1:0];
                r_be   <= w_head[USB3_BE_W+USB3_DATA_W-1:USB3_DATA_W];
            end
            if (w_accept)              r_words_sent <= r_words_sent + 32'd1;
            if (push_word && fifo_full) r_overflow  <= 1'b1;
        end
    end

    assign FT_WR         = r_ft_wr_n;
    assign usb3_data_oe  = r_oe;
    assign usb3_data_out = r_data;
    assign usb3_be_out   = r_be;
    assign overflow      = r_overflow;
    assign words_sent    = r_words_sent;
    assign tx_busy       = (r_state != TX_IDLE);

endmodule

// File: tb/tb_usb3_tx_if.sv
// Self-checking bench for usb3_tx_if: scoreboard of queued words against words seen on the bus.
module tb_usb3_tx_if;

    logic        ftdi_clk = 1'b0;
    logic        reset = 1'b1;
    logic        FT_TXE = 1'b1;
    logic        rx_active = 1'b0;
    logic        push_word = 1'b0;
    logic [31:0] push_data = '0;
    logic [3:0]  push_be = '0;
    logic        FT_WR;
    logic [31:0] usb3_data_out;
    logic [3:0]  usb3_be_out;
    logic        usb3_data_oe;
    logic        tx_busy;
    logic        fifo_full;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic [31:0] words_sent;

    int          checks = 0;
    int          errors = 0;
    logic [35:0] sb [$];
    logic [35:0] exp_word;

    usb3_tx_if #(.FIFO_DEPTH(16)) dut (
        .ftdi_clk      (ftdi_clk),
        .reset         (reset),
        .FT_TXE        (FT_TXE),
        .FT_WR         (FT_WR),
        .usb3_data_out (usb3_data_out),
        .usb3_be_out   (usb3_be_out),
        .usb3_data_oe  (usb3_data_oe),
        .rx_active     (rx_active),
        .tx_busy       (tx_busy),
        .push_word     (push_word),
        .push_data     (push_data),
        .push_be       (push_be),
        .fifo_full     (fifo_full),
        .fifo_level    (fifo_level),
        .overflow      (overflow),
        .words_sent    (words_sent)
    );

    always #5 ftdi_clk = ~ftdi_clk;

    // Bus monitor: a transfer happens at the coming edge when FT_WR and FT_TXE are both low.
    always @(negedge ftdi_clk) begin
        if (reset === 1'b0 && FT_WR === 1'b0 && FT_TXE === 1'b0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL bus_unexpected_word: got %h, expected no transfer", usb3_data_out);
            end else begin
                exp_word = sb.pop_front();
                if ({usb3_be_out, usb3_data_out} !== exp_word) begin
                    errors++;
                    $display("FAIL bus_word: got be=%h data=%h, expected be=%h data=%h",
                             usb3_be_out, usb3_data_out, exp_word[35:32], exp_word[31:0]);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge ftdi_clk);
        #1;
    endtask

    task automatic do_reset;
        reset     = 1'b1;
        push_word = 1'b0;
        FT_TXE    = 1'b1;
        rx_active = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic push_one(input logic [31:0] d, input bit accept);
        push_word = 1'b1;
        push_data = d;
        push_be   = d[3:0] ^ 4'h5;
        if (accept) sb.push_back({d[3:0] ^ 4'h5, d});
        tick();
        push_word = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles, input string name);
        int n = 0;
        while ((sb.size() != 0 || tx_busy !== 1'b0) && n < max_cycles) begin
            tick();
            n++;
        end
        checks++;
        if (n >= max_cycles) begin
            errors++;
            $display("FAIL %s_drain_timeout: %0d words still pending, expected 0", name, sb.size());
        end
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        push_word = 1'b1;
        push_data = 32'hDEAD_BEEF;
        FT_TXE    = 1'b0;
        repeat (3) tick();
        checks++;
        if ({FT_WR, usb3_data_oe, tx_busy, fifo_full, overflow} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl: got wr,oe,busy,full,ovf=%b, expected 10000",
                     {FT_WR, usb3_data_oe, tx_busy, fifo_full, overflow});
        end
        checks++;
        if ({usb3_be_out, usb3_data_out} !== 36'h0) begin
            errors++;
            $display("FAIL reset_data: got %h, expected 0", {usb3_be_out, usb3_data_out});
        end
        checks++;
        if (words_sent !== 32'd0) begin
            errors++;
            $display("FAIL reset_words_sent: got %0d, expected 0", words_sent);
        end
        push_word = 1'b0;
        reset     = 1'b0;
        tick();
        tick();
        checks++;
        if (fifo_level !== 5'd0 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_nothing_enqueued: got level=%0d busy=%b, expected 0 0", fifo_level, tx_busy);
        end
    endtask

    task automatic test_back_to_back;
        int  lows = 0;
        int  runs = 0;
        logic prev = 1'b1;
        do_reset();
        FT_TXE = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc < 8) begin
                push_word = 1'b1;
                push_data = 32'(cyc + 1);
                push_be   = push_data[3:0] ^ 4'h5;
                sb.push_back({push_be, push_data});
            end else begin
                push_word = 1'b0;
            end
            tick();
            if (FT_WR === 1'b0) begin
                lows++;
                if (prev) runs++;
            end
            prev = FT_WR;
        end
        checks++;
        if (lows !== 8 || runs !== 1) begin
            errors++;
            $display("FAIL burst_wr_low: got %0d low cycles in %0d runs, expected 8 in 1", lows, runs);
        end
        checks++;
        if (words_sent !== 32'd8) begin
            errors++;
            $display("FAIL burst_words_sent: got %0d, expected 8", words_sent);
        end
        checks++;
        if (usb3_data_oe !== 1'b0 || tx_busy !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL burst_idle: got oe=%b busy=%b pending=%0d, expected 0 0 0",
                     usb3_data_oe, tx_busy, sb.size());
        end
    endtask

    task automatic test_hold;
        int n = 0;
        do_reset();
        for (int i = 1; i <= 8; i++) push_one(32'(i), 1'b1);
        FT_TXE = 1'b0;
        while (!(usb3_data_out === 32'd4 && FT_WR === 1'b0) && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 30) begin
            errors++;
            $display("FAIL hold_reach_word4: got data=%h wr=%b, expected data=4 wr=0", usb3_data_out, FT_WR);
        end
        FT_TXE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (FT_WR !== 1'b1 || usb3_data_out !== 32'd4 || usb3_data_oe !== 1'b1) begin
                errors++;
                $display("FAIL hold_cycle%0d: got wr=%b data=%h oe=%b, expected 1 4 1",
                         i, FT_WR, usb3_data_out, usb3_data_oe);
            end
        end
        FT_TXE = 1'b0;
        tick();
        checks++;
        if (FT_WR !== 1'b0 || usb3_data_out !== 32'd4) begin
            errors++;
            $display("FAIL hold_resend: got wr=%b data=%h, expected 0 4", FT_WR, usb3_data_out);
        end
        wait_drain(40, "hold");
        checks++;
        if (words_sent !== 32'd8) begin
            errors++;
            $display("FAIL hold_words_sent: got %0d, expected 8", words_sent);
        end
    endtask

    task automatic test_overflow;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            push_one(32'h100 + 32'(i), i < 16);
            if (i == 15) begin
                checks++;
                if (fifo_full !== 1'b1 || fifo_level !== 5'd16 || overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_full: got full=%b level=%0d ovf=%b, expected 1 16 0",
                             fifo_full, fifo_level, overflow);
                end
            end
        end
        checks++;
        if (overflow !== 1'b1 || fifo_level !== 5'd16) begin
            errors++;
            $display("FAIL ovf_sticky: got ovf=%b level=%0d, expected 1 16", overflow, fifo_level);
        end
        FT_TXE = 1'b0;
        wait_drain(60, "ovf");
        checks++;
        if (words_sent !== 32'd16 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_words_sent: got %0d ovf=%b, expected 16 1", words_sent, overflow);
        end
    endtask

    task automatic test_rx_active;
        do_reset();
        rx_active = 1'b1;
        FT_TXE    = 1'b0;
        for (int i = 0; i < 4; i++) push_one(32'hA000 + 32'(i), 1'b1);
        repeat (3) tick();
        checks++;
        if (tx_busy !== 1'b0 || usb3_data_oe !== 1'b0 || FT_WR !== 1'b1 || fifo_level !== 5'd4) begin
            errors++;
            $display("FAIL rx_blocked: got busy=%b oe=%b wr=%b level=%0d, expected 0 0 1 4",
                     tx_busy, usb3_data_oe, FT_WR, fifo_level);
        end
        rx_active = 1'b0;
        tick();
        checks++;
        if (tx_busy !== 1'b1 || usb3_data_oe !== 1'b1 || FT_WR !== 1'b1) begin
            errors++;
            $display("FAIL rx_release_turn: got busy=%b oe=%b wr=%b, expected 1 1 1",
                     tx_busy, usb3_data_oe, FT_WR);
        end
        wait_drain(30, "rx");
        checks++;
        if (words_sent !== 32'd4) begin
            errors++;
            $display("FAIL rx_words_sent: got %0d, expected 4", words_sent);
        end
    endtask

    task automatic test_reset_mid_burst;
        int n = 0;
        do_reset();
        FT_TXE = 1'b0;
        for (int i = 0; i < 6; i++) push_one(32'hC000 + 32'(i), 1'b1);
        while (FT_WR !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL mid_reach_write: got wr=%b, expected 0", FT_WR);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (FT_WR !== 1'b1 || usb3_data_oe !== 1'b0 || fifo_level !== 5'd0 ||
            words_sent !== 32'd0 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_async: got wr=%b oe=%b level=%0d sent=%0d busy=%b, expected 1 0 0 0 0",
                     FT_WR, usb3_data_oe, fifo_level, words_sent, tx_busy);
        end
        sb.delete();
        tick();
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if (tx_busy !== 1'b0 || fifo_level !== 5'd0 || words_sent !== 32'd0) begin
            errors++;
            $display("FAIL mid_after_release: got busy=%b level=%0d sent=%0d, expected 0 0 0",
                     tx_busy, fifo_level, words_sent);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_hold();
        test_overflow();
        test_rx_active();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb3_tx_if.md
# usb3_tx_if

Transmit-direction companion to the FT601 receive interface: moves 32-bit words from FPGA logic to the host through the FT601 245-synchronous FIFO write path. Contains a single-clock buffering FIFO on the FPGA side and a write state machine on the chip side. Entirely in the `ftdi_clk` domain; any crossing from `fpga_clk` is done upstream. Arbitrates against the receive path through `rx_active`/`tx_busy`.

## Interface
Parameters:
- `FIFO_DEPTH`, 16, buffer depth in words; power of 2, range 4..256.
- `LVL_W`, `$clog2(FIFO_DEPTH)+1`, width of `fifo_level`; derived, not overridden.

Ports:
- `ftdi_clk` in 1: 100 MHz FT601 clock, sole clock.
- `reset` in 1: asynchronous, active-high.
- `FT_TXE` in 1: active-low; FT601 has space for write data.
- `FT_WR` out 1: active-low write strobe, registered.
- `usb3_data_out` out 32: write data, registered.
- `usb3_be_out` out 4: byte enables, registered.
- `usb3_data_oe` out 1: active-high tri-state enable for the shared data/BE pads.
- `rx_active` in 1: receive path owns the bus (OE_N low); blocks new bursts.
- `tx_busy` out 1: high whenever state is not IDLE.
- `push_word` in 1: write `push_data`/`push_be` into the FIFO.
- `push_data` in 32: word to send.
- `push_be` in 4: byte enables for the word.
- `fifo_full` out 1: FIFO holds `FIFO_DEPTH` words.
- `fifo_level` out LVL_W: words currently buffered, excluding the word in the output register.
- `overflow` out 1: sticky; push attempted while full.
- `words_sent` out 32: count of words accepted by the FT601; wraps mod 2^32.

## Operation
- FIFO: show-ahead single-clock FIFO.
  - A push is accepted only if `fifo_full` is 0 at the edge. A push while full is dropped and sets `overflow`.
  - Push and pop on the same edge (not full) leave the level unchanged.
  - Read and write pointers wrap mod `FIFO_DEPTH`.
- State machine (registered outputs follow state):
  - IDLE: `oe`=0, `FT_WR`=1. Moves to TURN when FIFO is non-empty, `FT_TXE`=0 and `rx_active`=0. On that edge, pop the head into the data/BE registers.
  - TURN: `oe`=1, `FT_WR`=1. One-cycle bus turnaround. Moves to WRITE if `FT_TXE`=0, else to HOLD.
  - WRITE: `oe`=1, `FT_WR`=0. Each edge with `FT_TXE`=0 counts as one word accepted and increments `words_sent`. Then:
    - FIFO non-empty and `rx_active`=0: pop the next word into the output registers and stay in WRITE.
    - Otherwise: go to IDLE.
    - On an edge with `FT_TXE`=1: the word is not accepted; go to HOLD with data held.
  - HOLD: `oe`=1, `FT_WR`=1, data held. Moves to WRITE when `FT_TXE`=0. Ignores `rx_active`, because a popped word is never discarded.
- `tx_busy` tells the receive path to defer asserting OE_N.

## Timing
- Reset (async assert, sync release): state IDLE, FIFO empty, `fifo_level`=0, `fifo_full`=0, `FT_WR`=1, `usb3_data_oe`=0, `usb3_data_out`=0, `usb3_be_out`=0, `overflow`=0, `words_sent`=0, `tx_busy`=0.
- Reset mid-burst: outputs go to their reset values immediately. Buffered and in-flight words are lost.
- Latency, push at edge k into an empty FIFO with `FT_TXE`=0:
  - TURN at k+1.
  - `FT_WR` low after k+2.
  - Accepted at edge k+3.
- Sustained throughput: one word per clock while in WRITE.
- `FT_TXE` is sampled raw at each edge, with no synchroniser, since it is the same clock domain.
- A word is transferred only on an edge where registered `FT_WR`=0 and `FT_TXE`=0.
- `fifo_level` and `fifo_full` update on the edge after a push or pop.

## Structure
- Shared package `usb3_pkg`:
  - `usb3_tx_state_t` enum (IDLE, TURN, WRITE, HOLD).
  - `USB3_DATA_W`=32 and `USB3_BE_W`=4.
  - Shared with the receive interface.
- Sub-module `usb3_tx_fifo`: parameterised show-ahead single-clock FIFO with level/full/empty outputs, instantiated once. The state machine, output registers and counter live in `usb3_tx_if`.

## Test plan
- Reset with `push_word`=1 and `FT_TXE`=0 held -> all outputs at reset values; nothing enqueued while `reset`=1.
- Push 0x00000001..0x00000008 back-to-back, `FT_TXE`=0 -> `FT_WR` low for exactly 8 consecutive cycles, data in order, `words_sent`=8, return to IDLE with `usb3_data_oe`=0.
- Mid-burst, `FT_TXE`=1 for 3 cycles while 0x00000004 is on the bus -> HOLD, 0x00000004 retained and re-sent once `FT_TXE`=0, no duplicate or lost word, `words_sent`=8 at end.
- `FIFO_DEPTH`=16, `FT_TXE`=1, push 17 words -> `fifo_full`=1 after the 16th, `overflow`=1, `fifo_level`=16; release `FT_TXE` -> exactly 16 words sent.
- `rx_active`=1 with 4 words queued -> stays IDLE, `tx_busy`=0; drop `rx_active` -> TURN on next edge.
- Assert `reset` during WRITE -> `FT_WR`=1 and `usb3_data_oe`=0 immediately, `fifo_level`=0.
